delta_rd_stream: RTL

DELTA_RD_STREAM -- requirements
Module: delta_rd_stream

---
 rtl/delta_rd_stream.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/delta_rd_stream.sv
// ----------------------------------------------------------------------------
// delta_rd_stream
//   Reads a burst of cfg_len consecutive SRAM words, starting at cfg_base and
//   wrapping modulo SRAM_DEPTH. The words go out on a valid/ready stream. A
//   2-entry output FIFO and a 1-deep in-flight flag keep at most two words
//   ahead of the sink. This sustains 1 word/cycle when the sink is always
//   ready.
//
// Ports
//   clk, rst_n      : clock (posedge); asynchronous active-low reset
//   cfg_start       : start request, accepted only while cfg_rdy
//   cfg_base        : first word address of the burst
//   cfg_len         : number of words (0 = complete immediately)
//   cfg_rdy         : block is idle and can take a start
//   abort           : synchronous cancel of the running burst (no done)
//   sram_read_en    : SRAM read strobe; data returns on the next cycle
//   sram_addr_r     : SRAM read address
//   sram_data_out   : SRAM read data
//   out_vld/out_rdy : stream handshake
//   out_dat         : stream data (FIFO head)
//   busy            : burst in progress (READ or DRAIN)
//   done            : one-cycle pulse after the final word, or after a
//                     zero-length start
// ----------------------------------------------------------------------------
module delta_rd_stream #(
    parameter int SRAM_DEPTH_BIT = 6,
    parameter int SRAM_DEPTH     = 2**SRAM_DEPTH_BIT,
    parameter int SRAM_WIDTH     = 28
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_start,
    input  logic [SRAM_DEPTH_BIT-1:0] cfg_base,
    input  logic [SRAM_DEPTH_BIT:0]   cfg_len,
    output logic                      cfg_rdy,
    input  logic                      abort,
    output logic                      sram_read_en,
    output logic [SRAM_DEPTH_BIT-1:0] sram_addr_r,
    input  logic [SRAM_WIDTH-1:0]     sram_data_out,
    output logic                      out_vld,
    input  logic                      out_rdy,
    output logic [SRAM_WIDTH-1:0]     out_dat,
    output logic                      busy,
    output logic                      done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [SRAM_DEPTH_BIT-1:0] ADDR_LAST = SRAM_DEPTH_BIT'(SRAM_DEPTH - 1);
    localparam logic [SRAM_DEPTH_BIT:0]   LEN_ONE   = (SRAM_DEPTH_BIT+1)'(1);

    logic [1:0]                r_state;
    logic [SRAM_DEPTH_BIT-1:0] r_addr;
    logic [SRAM_DEPTH_BIT:0]   r_remain;
    logic                      r_inflight;
    logic [SRAM_WIDTH-1:0]     r_fifo [0:1];
    logic                      r_wptr;
    logic                      r_rptr;
    logic [1:0]                r_cnt;
    logic                      r_done;

    logic                      w_pop;
    logic                      w_push;
    logic [2:0]                w_occ;
    logic                      w_issue;
    logic                      w_accept;
    logic                      w_last_hs;
    logic                      w_kill;
    logic [SRAM_DEPTH_BIT-1:0] w_addr_nxt;

    always_comb begin
        w_pop      = (r_cnt != 2'd0) && out_rdy;
        w_push     = r_inflight;
        w_occ      = {1'b0, r_cnt} + {2'b00, r_inflight};
        // An issue at occupancy 2 only fits when a word leaves in the same cycle.
        w_issue    = (r_state == ST_READ) && !abort && (r_remain != '0) &&
                     ((w_occ < 3'd2) || ((w_occ == 3'd2) && w_pop));
        w_accept   = (r_state == ST_IDLE) && cfg_start && !abort;
        w_last_hs  = (r_state == ST_DRAIN) && w_pop && (r_cnt == 2'd1) && !r_inflight;
        w_kill     = abort && (r_state != ST_IDLE);
        w_addr_nxt = (r_addr == ADDR_LAST) ? '0 : r_addr + 1'b1;
    end

    // Burst control: state, address, remaining read count, done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_remain   <= '0;
            r_inflight <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_inflight <= w_issue;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr   <= cfg_base;
                        r_remain <= cfg_len;
                        if (cfg_len != '0) r_state <= ST_READ;
                        else               r_done  <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (abort) begin
                        r_state  <= ST_IDLE;
                        r_remain <= '0;
                    end else if (w_issue) begin
                        r_addr   <= w_addr_nxt;
                        r_remain <= r_remain - 1'b1;
                        if (r_remain == LEN_ONE) r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else if (w_last_hs) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Output FIFO: two entries. Push comes from the in-flight read and pop
    // from the stream handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) r_fifo[i] <= '0;
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_cnt  <= 2'd0;
        end else if (w_kill) begin
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_cnt  <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= sram_data_out;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) r_rptr <= ~r_rptr;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_comb begin
        cfg_rdy      = (r_state == ST_IDLE);
        busy         = (r_state == ST_READ) || (r_state == ST_DRAIN);
        done         = r_done;
        sram_read_en = w_issue;
        sram_addr_r  = r_addr;
        out_vld      = (r_cnt != 2'd0);
        out_dat      = r_fifo[r_rptr];
    end

endmodule
